// File: rtl/ram_burst_master_pkg.sv
// Shared definitions for the RAM burst master: default widths and the
// controller state encoding.
package ram_burst_master_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;
    localparam int LEN_W_DEF  = 11;
    localparam int RAM_DEPTH  = 1 << ADDR_W_DEF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/ram_rd_fifo.sv
// Two-entry read-return FIFO. It absorbs the RAM's registered read latency so
// the read stream can be stalled without losing words that are already in flight.
module ram_rd_fifo #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] din_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] dout_o,
    output logic [1:0]        count_o
);

    logic [DATA_W-1:0] mem_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;

    // Storage, pointers and occupancy; a push and a pop in the same cycle are both honoured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ram_burst_master.sv
// Burst initiator for the single-port synchronous RAM. It takes one read or
// write burst command at a time, streams write words straight onto the RAM
// pins, and paces read issues so the 2-entry return FIFO can never overflow.
module ram_burst_master
    import ram_burst_master_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam int unsigned DEPTH = (ADDR_W == ADDR_W_DEF) ? RAM_DEPTH : (1 << ADDR_W);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  cur_addr_q, cur_addr_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic               inflight_q, inflight_d;
    logic               issue;
    logic               pop;
    logic [1:0]         fifo_cnt;
    logic [DATA_W-1:0]  fifo_dout;
    logic [ADDR_W-1:0]  next_addr;

    assign rd_valid  = (fifo_cnt != 2'd0);
    assign pop       = rd_valid && rd_ready;
    assign rd_data   = fifo_dout;
    assign ram_addr  = cur_addr_q;
    assign next_addr = (cur_addr_q == LAST_ADDR) ? '0 : cur_addr_q + 1'b1;

    // The word read last cycle lands in the FIFO this cycle.
    ram_rd_fifo #(.DATA_W(DATA_W)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (inflight_q),
        .din_i   (ram_dout),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .count_o (fifo_cnt)
    );

    // State, address, remaining count and read-in-flight registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            inflight_q  <= inflight_d;
        end
    end

    // Next-state and output decode; ram_we follows wr_valid combinationally so the RAM
    // captures the word on the handshake edge.
    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        issue       = 1'b0;
        cmd_ready   = 1'b0;
        wr_ready    = 1'b0;
        ram_we      = 1'b0;
        ram_din     = '0;
        done        = 1'b0;
        busy        = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    cur_addr_d  = cmd_addr;
                    remaining_d = cmd_len;
                    if (cmd_len == '0)  state_d = ST_DONE;
                    else if (cmd_write) state_d = ST_WRITE;
                    else                state_d = ST_READ;
                end
            end
            ST_WRITE: begin
                wr_ready = 1'b1;
                ram_we   = wr_valid;
                ram_din  = wr_data;
                if (wr_valid) begin
                    cur_addr_d  = next_addr;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == LEN_W'(1)) state_d = ST_DONE;
                end
            end
            ST_READ: begin
                // Issue only if the FIFO can still hold every word already committed.
                issue = (({1'b0, fifo_cnt} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));
                if (issue) begin
                    cur_addr_d  = next_addr;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == LEN_W'(1)) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!inflight_q && ((fifo_cnt - {1'b0, pop}) == 2'd0)) state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign inflight_d = issue;

endmodule

// File: tb/tb_ram_burst_master.sv
module tb_ram_burst_master;
    import ram_burst_master_pkg::*;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int LW = 11;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          wr_valid = 1'b0, wr_ready;
    logic [DW-1:0] wr_data = '0;
    logic          rd_valid, rd_ready = 1'b0;
    logic [DW-1:0] rd_data;
    logic          busy, done, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din, ram_dout;

    logic [DW-1:0] mem [RAM_DEPTH] = '{default: '0};
    logic [DW-1:0] exp_q [$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    int we_cnt = 0;

    ram_burst_master dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy), .done(done),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // Behavioural 1024x32 single-port RAM with registered read.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done)   done_cnt = done_cnt + 1;
        if (ram_we) we_cnt = we_cnt + 1;
    end

    task automatic issue_cmd(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] l,
                             output int hs);
        bit ok;
        ok = 0;
        hs = -1;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cmd_ready) begin hs = cyc; ok = 1; break; end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL cmd_handshake: cmd_ready stayed 0, required 1");
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic stream_write(input logic [DW-1:0] base, input int n);
        bit ok;
        for (int i = 0; i < n; i++) begin
            ok = 0;
            wr_valid = 1'b1;
            wr_data  = base + DW'(i);
            for (int t = 0; t < 50; t++) begin
                @(negedge clk);
                if (wr_ready) begin ok = 1; break; end
                @(posedge clk); #1;
            end
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL wr_handshake word %0d: wr_ready stayed 0, required 1", i);
            end
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        wr_data  = '0;
    endtask

    // Drain n read words; mode 0 = rd_ready always 1, mode 1 = pattern 1,0,0 repeating.
    task automatic consume(input int mode, input int n, input int hs, input bit chk_lat);
        int got, first, prev_pop, last_pop, done_cyc, k;
        bit held_v, saw_done;
        logic [DW-1:0] held_d, e;
        got = 0; first = -1; prev_pop = -1; last_pop = -1; done_cyc = -1; k = 0;
        held_v = 0; saw_done = 0; held_d = '0;
        for (int t = 0; t < 300 && !(got == n && saw_done); t++) begin
            rd_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
            @(negedge clk);
            checks++;
            if (dut.u_fifo.count_o > 2'd2) begin
                errors++;
                $display("FAIL fifo_depth: count %0d, required <= 2", dut.u_fifo.count_o);
            end
            if (held_v) begin
                checks++;
                if (rd_valid !== 1'b1 || rd_data !== held_d) begin
                    errors++;
                    $display("FAIL rd_stall_hold: valid=%b data=%h, required valid=1 data=%h",
                             rd_valid, rd_data, held_d);
                end
            end
            held_v = 0;
            if (rd_valid) begin
                if (first < 0) first = cyc;
                if (rd_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL rd_extra_word: got %h, required no word", rd_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (rd_data !== e) begin
                            errors++;
                            $display("FAIL rd_data word %0d: got %h, required %h", got, rd_data, e);
                        end
                    end
                    if (mode == 0 && prev_pop >= 0) begin
                        checks++;
                        if (cyc != prev_pop + 1) begin
                            errors++;
                            $display("FAIL rd_throughput: pop at cycle %0d, required %0d",
                                     cyc, prev_pop + 1);
                        end
                    end
                    prev_pop = cyc;
                    last_pop = cyc;
                    got++;
                end else begin
                    held_v = 1;
                    held_d = rd_data;
                end
            end
            if (done) begin saw_done = 1; done_cyc = cyc; end
            k++;
            @(posedge clk); #1;
        end
        rd_ready = 1'b0;
        checks++;
        if (got != n || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rd_count: got %0d words (%0d left expected), required %0d",
                     got, exp_q.size(), n);
        end
        checks++;
        if (!saw_done || done_cyc != last_pop + 1) begin
            errors++;
            $display("FAIL rd_done_timing: done at cycle %0d, required %0d", done_cyc, last_pop + 1);
        end
        if (chk_lat) begin
            checks++;
            if (first != hs + 3) begin
                errors++;
                $display("FAIL rd_latency: first rd_valid at cycle %0d, required %0d", first, hs + 3);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if ({cmd_ready, wr_ready, rd_valid, busy, done, ram_we} !== 6'b100000 ||
            rd_data !== '0 || ram_addr !== '0 || ram_din !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rdy/wrr/rdv/busy/done/we=%b rd_data=%h addr=%h din=%h, required 100000 0 0 0",
                     {cmd_ready, wr_ready, rd_valid, busy, done, ram_we}, rd_data, ram_addr, ram_din);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_write_wrap();
        int hs, d0;
        d0 = done_cnt;
        issue_cmd(1'b1, 10'h3FE, 11'd4, hs);
        stream_write(32'h0000_00A0, 4);
        @(negedge clk);
        checks++;
        if (wr_ready !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL wr_end: wr_ready=%b done=%b, required 0 1", wr_ready, done);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (done_cnt - d0 != 1 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL wr_done_once: pulses=%0d cmd_ready=%b, required 1 1", done_cnt - d0, cmd_ready);
        end
        checks++;
        if (mem[10'h3FE] !== 32'hA0 || mem[10'h3FF] !== 32'hA1 ||
            mem[10'h000] !== 32'hA2 || mem[10'h001] !== 32'hA3) begin
            errors++;
            $display("FAIL wr_wrap_mem: %h %h %h %h, required a0 a1 a2 a3",
                     mem[10'h3FE], mem[10'h3FF], mem[10'h000], mem[10'h001]);
        end
    endtask

    task automatic test_read_wrap();
        int hs;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h0000_00A0 + DW'(i));
        issue_cmd(1'b0, 10'h3FE, 11'd4, hs);
        consume(0, 4, hs, 1'b1);
    endtask

    task automatic test_read_backpressure();
        int hs;
        issue_cmd(1'b1, 10'h100, 11'd8, hs);
        stream_write(32'hB000_0000, 8);
        for (int i = 0; i < 8; i++) exp_q.push_back(32'hB000_0000 + DW'(i));
        issue_cmd(1'b0, 10'h100, 11'd8, hs);
        consume(1, 8, hs, 1'b1);
    endtask

    task automatic test_zero_len();
        int hs, w0, d0;
        w0 = we_cnt;
        d0 = done_cnt;
        issue_cmd(1'b1, 10'h050, 11'd0, hs);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || cyc != hs + 1) begin
            errors++;
            $display("FAIL zero_len_done: done=%b busy=%b cycle=%0d, required 1 1 %0d",
                     done, busy, cyc, hs + 1);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || we_cnt != w0 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL zero_len_idle: cmd_ready=%b busy=%b writes=%0d pulses=%0d, required 1 0 0 1",
                     cmd_ready, busy, we_cnt - w0, done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid();
        int hs, d0;
        d0 = done_cnt;
        issue_cmd(1'b1, 10'h200, 11'd5, hs);
        wr_valid = 1'b1; wr_data = 32'hC000_0000;
        @(posedge clk); #1;
        wr_data = 32'hC000_0001;
        @(posedge clk); #1;
        wr_data = 32'hC000_0002;
        #1;
        checks++;
        if (ram_we !== 1'b1) begin
            errors++;
            $display("FAIL mid_burst_we: ram_we=%b, required 1", ram_we);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (ram_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_outputs: we=%b busy=%b done=%b cmd_ready=%b, required 0 0 0 1",
                     ram_we, busy, done, cmd_ready);
        end
        @(posedge clk); #1;
        wr_valid = 1'b0;
        wr_data  = '0;
        rst_n    = 1'b1;
        checks++;
        if (mem[10'h200] !== 32'hC000_0000 || mem[10'h201] !== 32'hC000_0001 ||
            mem[10'h202] !== 32'h0 || done_cnt != d0) begin
            errors++;
            $display("FAIL abort_mem: %h %h %h pulses=%0d, required c0000000 c0000001 0 0",
                     mem[10'h200], mem[10'h201], mem[10'h202], done_cnt - d0);
        end
        exp_q.push_back(32'hC000_0000);
        exp_q.push_back(32'hC000_0001);
        issue_cmd(1'b0, 10'h200, 11'd2, hs);
        consume(0, 2, hs, 1'b1);
    endtask

    task automatic test_back_to_back();
        int hs1, hs2, dcyc, wi;
        hs2 = -1; dcyc = -1; wi = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 10'h300; cmd_len = 11'd3;
        hs1 = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cmd_ready) begin hs1 = cyc; break; end
        end
        checks++;
        if (hs1 < 0) begin
            errors++;
            $display("FAIL b2b_first_cmd: cmd_ready stayed 0, required 1");
        end
        @(posedge clk); #1;
        cmd_write = 1'b0; cmd_len = 11'd3;
        for (int i = 0; i < 3; i++) exp_q.push_back(32'hD000_0000 + DW'(i));
        for (int t = 0; t < 100; t++) begin
            wr_valid = (wi < 3);
            wr_data  = 32'hD000_0000 + DW'(wi);
            @(negedge clk);
            if (wr_valid && wr_ready) wi++;
            if (done) dcyc = cyc;
            if (cmd_ready) begin hs2 = cyc; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wr_valid  = 1'b0;
        checks++;
        if (wi != 3 || dcyc < 0 || hs2 != dcyc + 1) begin
            errors++;
            $display("FAIL b2b_stall: words=%0d done_cycle=%0d second_hs=%0d, required 3 words and hs = done+1",
                     wi, dcyc, hs2);
        end
        consume(0, 3, hs2, 1'b1);
    endtask

    initial begin
        test_reset();
        test_write_wrap();
        test_read_wrap();
        test_read_backpressure();
        test_zero_len();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_burst_master.md
Name: ram_burst_master

Overview:
- Burst initiator for the 1024x32 single-port synchronous RAM.
- Accepts a read or write burst command (base address, length) over valid/ready.
- Streams write data into the RAM, or streams read data out with backpressure.
- Drives the RAM's clk-domain we/addr/din pins and absorbs its 1-cycle registered read latency.
- Sits between the datapath/DMA side and the ram instance.

Parameters:
- ADDR_W, 10, RAM address width (depth 2^ADDR_W words)
- DATA_W, 32, RAM data width
- LEN_W, 11, burst length field width (max 1024 words)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both high
- cmd_write  in  1  1=write burst, 0=read burst
- cmd_addr  in  ADDR_W  base word address
- cmd_len  in  LEN_W  word count; 0 = no-op
- wr_valid  in  1  write word offered
- wr_ready  out  1  write word accepted when both high
- wr_data  in  DATA_W  write word
- rd_valid  out  1  read word available
- rd_ready  in  1  consumer accepts read word
- rd_data  out  DATA_W  read word
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse at burst completion
- ram_we  out  1  to RAM we
- ram_addr  out  ADDR_W  to RAM addr
- ram_din  out  DATA_W  to RAM din
- ram_dout  in  DATA_W  from RAM Dout; valid the cycle after a read is presented

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; address and count registers clear; FIFO empties; in-flight flag clears.
  - Outputs: cmd_ready=1, wr_ready=0, rd_valid=0, rd_data=0, busy=0, done=0, ram_we=0, ram_addr=0, ram_din=0.
- States and transitions:
  - IDLE -> WRITE, READ or DONE.
  - WRITE -> DONE.
  - READ -> DRAIN -> DONE.
  - DONE -> IDLE.
- IDLE:
  - cmd_ready=1.
  - On handshake, latch cur_addr=cmd_addr and remaining=cmd_len.
  - cmd_len=0 -> DONE. Otherwise cmd_write=1 -> WRITE, cmd_write=0 -> READ.
  - cmd_ready=0 in every other state; commands offered while busy stall.
- WRITE:
  - wr_ready=1.
  - ram_we = wr_valid (combinational), ram_addr=cur_addr, ram_din=wr_data. The RAM captures the word on the same rising edge as the handshake.
  - Each handshake: cur_addr += 1 modulo 2^ADDR_W (0x3FF wraps to 0x000), remaining -= 1.
  - The handshake that takes remaining to 0 -> DONE.
  - A cycle with wr_valid=0 issues no write.
- READ:
  - ram_we=0, ram_addr=cur_addr.
  - A read issues in a cycle when occupancy + inflight - pop < 2:
    - occupancy = FIFO entries;
    - inflight = a read issued last cycle;
    - pop = rd_valid && rd_ready.
  - An issue advances cur_addr (with wrap) and decrements remaining. If the cycle does not issue, cur_addr holds.
  - The cycle after an issue, ram_dout is pushed into the FIFO.
  - After the final issue -> DRAIN.
- DRAIN:
  - No issues.
  - -> DONE when inflight=0 and the FIFO is empty after the pop.
- DONE: done=1 and busy=1 for exactly one cycle, then -> IDLE.
- Read latency: if the command handshake is in cycle C0, the first read is presented in C1, ram_dout is valid in C2, and rd_valid=1 in C3.
- Read throughput: sustained 1 word/cycle with rd_ready held high.
- Read output: rd_data is the FIFO head, in address order. It holds stable while rd_valid=1 and rd_ready=0.
- Simultaneous push and pop on the FIFO are both honoured.
- The FIFO never overflows; this is guaranteed by the issue rule.
- In IDLE/DONE/DRAIN, ram_we=0. The RAM may perform harmless reads.
- Reset mid-burst:
  - Immediate abort with no done pulse.
  - ram_we drops asynchronously.
  - Data already written stays in the RAM; partial read data is discarded.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE/WRITE/READ/DRAIN/DONE;
  - default ADDR_W/DATA_W/LEN_W;
  - RAM_DEPTH = 2^ADDR_W.
- One sub-module: ram_rd_fifo, a 2-entry DATA_W synchronous FIFO with async active-low reset and push/pop/count ports.

Test Plan:
- Write len=4 at addr=0x3FE with data A0..A3 and wr_valid continuous -> RAM[0x3FE]=A0, RAM[0x3FF]=A1, RAM[0x000]=A2, RAM[0x001]=A3; done pulses once; wr_ready=0 after the 4th word.
- Read len=4 at addr=0x3FE after the prior test, rd_ready=1 -> rd_data A0,A1,A2,A3 on 4 consecutive cycles; first rd_valid 3 cycles after the cmd handshake; done follows the last pop.
- Read len=8 with rd_ready toggling 1,0,0,1,... -> no word lost or duplicated; rd_data stable while stalled; at most 2 words buffered.
- cmd_len=0 write -> no ram_we; done one cycle after the handshake; back in IDLE with cmd_ready=1.
- rst_n low after 2 of 5 write words -> ram_we=0 immediately; busy=0, no done; next command is accepted normally.
- cmd_valid held high during an active burst -> cmd_ready stays 0 until IDLE; the second command starts the cycle after done.
